keypad_event_queue: RTL and testbench
=====================================

KEYPAD_EVENT_QUEUE -- requirements
Module: keypad_event_queue

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a key level is accepted; legal range 2..65535.
REQ-002 The block SHALL have port CLK, input, 1 bit: single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port RESETN, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Keypad, input, 10 bits: raw, asynchronous, bouncing digit keys; bit i is key i, active high.
REQ-005 The block SHALL have port KeypadHash, input, 1 bit: raw, asynchronous '#' key, active high.
REQ-006 The block SHALL have port FLUSH, input, 1 bit: synchronous clear of the queue, pending bits and OVERFLOW.
REQ-007 The block SHALL have port EV_READY, input, 1 bit: consumer accepts the head event.
REQ-008 The block SHALL have port EV_VALID, output, 1 bit: queue non-empty; head event is presented.
REQ-009 The block SHALL have port EV_CODE, output, 4 bits: head event code; 0-9 = digit, 4'hA = '#'.
REQ-010 The block SHALL have port ANY_PRESSED, output, 1 bit: OR of all 11 debounced key levels.
REQ-011 The block SHALL have port OVERFLOW, output, 1 bit: sticky flag, set when a press event is lost.

Function
REQ-012 Each of the 11 raw lines SHALL pass through a 2-flop synchronizer; downstream logic SHALL use only the second flop (s2).
REQ-013 Each line SHALL have a debounced level db and a 16-bit counter; counter SHALL be cleared in any cycle where s2 == db.
REQ-014 While s2 != db, the counter SHALL increment; on the edge where counter == DEBOUNCE_CYCLES-1 and s2 != db, db SHALL take s2 and the counter SHALL clear.
REQ-015 A db transition 0->1 SHALL set that line's pending bit on the same edge; 1->0 transitions SHALL generate no event.
REQ-016 A press on a line whose pending bit is already set SHALL drop the new event and set OVERFLOW; the existing pending bit is unchanged.
REQ-017 Each cycle, if the FIFO can accept, the lowest-index set pending bit (digits 0-9, then '#' as index 10) SHALL be pushed as EV_CODE and its pending bit cleared; at most one push per cycle.
REQ-018 The FIFO SHALL be 4 entries, first-word-fall-through; EV_VALID = (count != 0); EV_CODE = head entry, 4'h0 when empty.
REQ-019 Pop SHALL occur on an edge where EV_VALID && EV_READY; EV_READY while empty SHALL have no effect.
REQ-020 The FIFO "can accept" when count < 4, or count == 4 and a pop occurs in the same cycle; simultaneous push+pop SHALL leave count unchanged and preserve order.
REQ-021 When the FIFO is full without a pop, pending bits SHALL be held (back-pressure); no event is lost until REQ-016 applies.
REQ-022 FLUSH SHALL on the next edge empty the FIFO, clear all pending bits and clear OVERFLOW; synchronizers, db and counters SHALL be unaffected; a press detected on the FLUSH edge SHALL be discarded.
REQ-023 OVERFLOW SHALL clear only on reset or FLUSH.
REQ-024 Latency: a clean press on an idle, empty block SHALL raise EV_VALID DEBOUNCE_CYCLES+3 edges after the first edge sampling the raw line high.

Reset
REQ-025 While RESETN = 0, the block SHALL asynchronously set synchronizers, db, counters, pending bits, FIFO pointers and count to 0, and EV_VALID=0, EV_CODE=0, ANY_PRESSED=0, OVERFLOW=0.
REQ-026 A key held through reset deassertion SHALL produce exactly one press event once stable for DEBOUNCE_CYCLES after the synchronizer fills.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Bench SHALL cover: Keypad=10'h008 held, EV_READY=1 -> EV_VALID pulses 1 cycle at edge 7, EV_CODE=3; ANY_PRESSED=1 from edge 6.
REQ-028 Bench SHALL cover: Keypad[5] high for 3 cycles, then low -> no event; ANY_PRESSED stays 0.
REQ-029 Bench SHALL cover: Keypad=10'h201 and KeypadHash rise on the same cycle, EV_READY=1 -> codes 0, 9, A on consecutive cycles.
REQ-030 Bench SHALL cover: EV_READY=0, six distinct keys pressed -> 4 queued in index order, 2 pending, OVERFLOW=0; repeat of a pending key -> OVERFLOW=1; EV_READY=1 -> 6 events drained in order.
REQ-031 Bench SHALL cover: FIFO holding 2 events plus OVERFLOW=1, FLUSH pulse -> next edge EV_VALID=0, OVERFLOW=0; a key still held produces no new event.
REQ-032 Bench SHALL cover: RESETN dropped mid-debounce with 3 events queued -> outputs 0 immediately; after release with Keypad[2] still held, a single code-2 event appears.

Source files
------------

// File: rtl/keypad_event_queue.sv
// Debounced 11-key keypad that queues press events (digits 0-9, '#'=4'hA)
// into a 4-entry first-word-fall-through FIFO with sticky overflow.
module keypad_event_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [9:0] Keypad,
    input  logic       KeypadHash,
    input  logic       FLUSH,
    input  logic       EV_READY,
    output logic       EV_VALID,
    output logic [3:0] EV_CODE,
    output logic       ANY_PRESSED,
    output logic       OVERFLOW
);
    localparam int unsigned N_KEYS = 11;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned FCNT_W = 3;
    localparam int unsigned CODE_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] raw;
    logic [N_KEYS-1:0] s1_q, s2_q;
    logic [N_KEYS-1:0] db_q, db_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [N_KEYS-1:0] press;
    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              ev_valid_q, ev_valid_d;
    logic [CODE_W-1:0] ev_code_q, ev_code_d;
    logic              any_q, any_d;
    logic              pop, push, can_push;
    logic [CODE_W-1:0] sel;

    assign raw = {KeypadHash, Keypad};

    // Debounce, pending-bit arbitration and FIFO bookkeeping
    always_comb begin
        db_d       = db_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        press      = '0;
        sel        = '0;

        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
                press[i] = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        // Lowest index wins: scan downward so the last hit is the smallest
        for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
            if (pending_q[i]) sel = CODE_W'(i);
        end

        pop      = (count_q != '0) && EV_READY;
        can_push = (count_q != FCNT_W'(DEPTH)) || pop;
        push     = can_push && (pending_q != '0);

        if (FLUSH) begin
            pending_d  = '0;
            overflow_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                pending_d[sel]  = 1'b0;
                mem_d[wr_ptr_q] = sel;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + FCNT_W'(push) - FCNT_W'(pop);
            for (int i = 0; i < int'(N_KEYS); i++) begin
                if (press[i]) begin
                    if (pending_q[i]) overflow_d = 1'b1;
                    else              pending_d[i] = 1'b1;
                end
            end
        end

        ev_valid_d = (count_d != '0);
        ev_code_d  = ev_valid_d ? mem_d[rd_ptr_d] : '0;
        any_d      = |db_d;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            cnt_q      <= '{default: '0};
            pending_q  <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
            any_q      <= 1'b0;
        end else begin
            s1_q       <= raw;
            s2_q       <= s1_q;
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            any_q      <= any_d;
        end
    end

    assign EV_VALID    = ev_valid_q;
    assign EV_CODE     = ev_code_q;
    assign ANY_PRESSED = any_q;
    assign OVERFLOW    = overflow_q;
endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue with DEBOUNCE_CYCLES=4.
module tb_keypad_event_queue;
    logic       CLK = 1'b0;
    logic       RESETN;
    logic [9:0] Keypad;
    logic       KeypadHash;
    logic       FLUSH;
    logic       EV_READY;
    logic       EV_VALID;
    logic [3:0] EV_CODE;
    logic       ANY_PRESSED;
    logic       OVERFLOW;

    int tests_run = 0;
    int tests_failed = 0;

    keypad_event_queue #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK(CLK), .RESETN(RESETN), .Keypad(Keypad), .KeypadHash(KeypadHash),
        .FLUSH(FLUSH), .EV_READY(EV_READY), .EV_VALID(EV_VALID),
        .EV_CODE(EV_CODE), .ANY_PRESSED(ANY_PRESSED), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0; Keypad = '0; KeypadHash = 1'b0; FLUSH = 1'b0; EV_READY = 1'b0;
        tick(3);
        tests_run++;
        if ({EV_VALID, EV_CODE, ANY_PRESSED, OVERFLOW} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required 0000000", {EV_VALID, EV_CODE, ANY_PRESSED, OVERFLOW});
        end
        RESETN = 1'b1;
        tick(2);
    endtask

    // Single clean press with consumer always ready
    task automatic test_single_press();
        logic       ev;
        logic [3:0] ec;
        logic       ea;
        EV_READY = 1'b1;
        Keypad   = 10'h008;
        for (int e = 1; e <= 9; e++) begin
            tick(1);
            ev = (e == 7);
            ec = (e == 7) ? 4'h3 : 4'h0;
            ea = (e >= 6);
            tests_run++;
            if (EV_VALID !== ev || EV_CODE !== ec || ANY_PRESSED !== ea) begin
                tests_failed++;
                $display("FAIL single_edge%0d: got v=%b c=%h a=%b required v=%b c=%h a=%b",
                         e, EV_VALID, EV_CODE, ANY_PRESSED, ev, ec, ea);
            end
        end
        Keypad = '0;
        tick(10);
        tests_run++;
        if (EV_VALID !== 1'b0 || ANY_PRESSED !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_release: got v=%b a=%b required v=0 a=0", EV_VALID, ANY_PRESSED);
        end
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        Keypad = 10'h020;
        tick(3);
        Keypad = '0;
        for (int e = 0; e < 12; e++) begin
            if (EV_VALID || ANY_PRESSED) seen++;
            tick(1);
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL glitch_filtered: got %0d active cycles required 0", seen);
        end
    endtask

    task automatic test_simultaneous();
        logic       ev;
        logic [3:0] ec;
        EV_READY   = 1'b1;
        Keypad     = 10'h201;
        KeypadHash = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            ev = (e >= 7 && e <= 9);
            ec = (e == 8) ? 4'h9 : (e == 9) ? 4'hA : 4'h0;
            tests_run++;
            if (EV_VALID !== ev || EV_CODE !== ec) begin
                tests_failed++;
                $display("FAIL simul_edge%0d: got v=%b c=%h required v=%b c=%h", e, EV_VALID, EV_CODE, ev, ec);
            end
        end
        Keypad = '0; KeypadHash = 1'b0;
        tick(10);
    endtask

    task automatic test_back_pressure();
        logic [3:0] exp_codes [6];
        exp_codes = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7};
        EV_READY = 1'b0;
        Keypad   = 10'h0BE;
        tick(15);
        tests_run++;
        if (EV_VALID !== 1'b1 || EV_CODE !== 4'h1 || OVERFLOW !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full: got v=%b c=%h o=%b required v=1 c=1 o=0", EV_VALID, EV_CODE, OVERFLOW);
        end
        Keypad = 10'h09E;
        tick(10);
        Keypad = 10'h0BE;
        tick(10);
        tests_run++;
        if (OVERFLOW !== 1'b1 || EV_CODE !== 4'h1) begin
            tests_failed++;
            $display("FAIL bp_overflow: got o=%b c=%h required o=1 c=1", OVERFLOW, EV_CODE);
        end
        EV_READY = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tests_run++;
            if (EV_VALID !== 1'b1 || EV_CODE !== exp_codes[j]) begin
                tests_failed++;
                $display("FAIL bp_drain%0d: got v=%b c=%h required v=1 c=%h", j, EV_VALID, EV_CODE, exp_codes[j]);
            end
            tick(1);
        end
        tests_run++;
        if (EV_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_empty_sticky: got v=%b o=%b required v=0 o=1", EV_VALID, OVERFLOW);
        end
        EV_READY = 1'b0;
        Keypad   = '0;
        tick(10);
    endtask

    // OVERFLOW is still set from the back-pressure scenario
    task automatic test_flush();
        EV_READY = 1'b0;
        Keypad   = 10'h041;
        tick(10);
        tests_run++;
        if (EV_VALID !== 1'b1 || EV_CODE !== 4'h0 || OVERFLOW !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_pre: got v=%b c=%h o=%b required v=1 c=0 o=1", EV_VALID, EV_CODE, OVERFLOW);
        end
        FLUSH = 1'b1;
        tick(1);
        FLUSH = 1'b0;
        tests_run++;
        if (EV_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_clear: got v=%b o=%b required v=0 o=0", EV_VALID, OVERFLOW);
        end
        tick(10);
        tests_run++;
        if (EV_VALID !== 1'b0 || ANY_PRESSED !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_held: got v=%b a=%b required v=0 a=1", EV_VALID, ANY_PRESSED);
        end
        Keypad = '0;
        tick(10);
    endtask

    task automatic test_reset_mid();
        int n_ev;
        int bad;
        n_ev = 0;
        bad  = 0;
        EV_READY = 1'b0;
        Keypad   = 10'h00B;
        tick(10);
        tests_run++;
        if (EV_VALID !== 1'b1 || EV_CODE !== 4'h0) begin
            tests_failed++;
            $display("FAIL rst_pre: got v=%b c=%h required v=1 c=0", EV_VALID, EV_CODE);
        end
        Keypad = 10'h00F;
        tick(3);
        RESETN = 1'b0;
        #1;
        tests_run++;
        if ({EV_VALID, EV_CODE, ANY_PRESSED, OVERFLOW} !== 7'b0) begin
            tests_failed++;
            $display("FAIL rst_async: got %b required 0000000", {EV_VALID, EV_CODE, ANY_PRESSED, OVERFLOW});
        end
        Keypad = 10'h004;
        tick(3);
        RESETN   = 1'b1;
        EV_READY = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick(1);
            if (EV_VALID) begin
                n_ev++;
                if (EV_CODE !== 4'h2) bad++;
            end
        end
        tests_run++;
        if (n_ev != 1 || bad != 0) begin
            tests_failed++;
            $display("FAIL rst_held_key: got %0d events (%0d wrong code) required 1 event code 2", n_ev, bad);
        end
        Keypad = '0;
        tick(10);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
